// File: rtl/sdp_pkg.sv
// Shared definitions for the SDP burst reader: controller state encoding and
// skid-buffer depth.
package sdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/sdp_skid_buf.sv
// Two-entry in-order buffer between the RAM read port and the output stream.
// Entry e0 is always the oldest word and drives dout directly.
module sdp_skid_buf
  import sdp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged, shift before append.
          if (count == 2'(BUF_DEPTH)) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign dout  = e0;

endmodule

// File: rtl/sdp_burst_reader.sv
// Burst reader for port b of a simple dual-port RAM: issues reads only when
// the skid buffer is guaranteed room, and streams words out with backpressure.
module sdp_burst_reader
  import sdp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]      doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remain;
  logic                  inflight;
  logic                  issue;
  logic                  pop;
  logic                  done_q;
  logic                  done_nxt;
  logic [1:0]            occ;

  assign pop = m_valid & m_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) state_nxt = READ;
          else           done_nxt  = 1'b1;
        end
      end
      READ: begin
        // occupancy + inflight - pop < 2, rearranged to stay unsigned
        if (({1'b0, occ} + 3'(inflight)) < (3'd2 + 3'(pop))) begin
          issue = 1'b1;
          if (remain == LEN_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Finish on the edge of the last pop so done follows it by one clock.
        if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      inflight <= 1'b0;
      addr     <= '0;
      remain   <= '0;
    end else begin
      state    <= state_nxt;
      done_q   <= done_nxt;
      inflight <= issue;
      if ((state == IDLE) && start && (len != '0)) begin
        addr   <= base_addr;
        remain <= len;
      end else if (issue) begin
        addr   <= addr + ADDR_WIDTH'(1);
        remain <= remain - LEN_WIDTH'(1);
      end
    end
  end

  sdp_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (doutb),
    .pop   (pop),
    .count (occ),
    .valid (m_valid),
    .dout  (m_data)
  );

  assign busy  = (state != IDLE);
  assign done  = done_q;
  assign enb   = issue;
  assign addrb = addr;

endmodule

// File: tb/tb_sdp_burst_reader.sv
// Bench for sdp_burst_reader with a 4-word behavioural RAM on port b; bursts are
// checked word-by-word against addresses computed from base/len modulo 4.
module tb_sdp_burst_reader;

  localparam int unsigned AW = 2;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, enb, m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb = '0;
  logic [31:0]   m_data;
  logic [31:0]   mem [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (enb) doutb <= mem[addrb];

  sdp_burst_reader #(
    .WIDTH      (32),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1,0,1..., 2: random ready.
  // intrude: pulse a second start mid-burst. abort: return after that many pops.
  task automatic run_burst(input int b, input int l, input int mode,
                           input bit intrude, input int abort);
    int issued = 0, popped = 0, occ = 0, last_pop_c = -1;
    bit inflight_prev = 0, stall_prev = 0, finished = 0, pop;
    bit exp_done, exp_busy;
    logic [31:0] stall_data = '0;
    logic [5:0] patv = 6'b100101;
    start = 1'b1;
    base_addr = AW'(b);
    len = LW'(l);
    for (int c = 1; c <= 80 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (intrude && c == 2) begin
        start = 1'b1;
        base_addr = AW'(b + 2);
        len = LW'(3);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = patv[5 - ((c - 1) % 6)];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      pop = m_valid && m_ready;
      chk("valid_vs_occ", 32'(m_valid), 32'(occ > 0));
      if (stall_prev) chk("stall_stable", m_data, stall_data);
      if (enb) begin
        chk("enb_room", 32'((occ + int'(inflight_prev) - int'(pop)) < 2), 32'd1);
        chk("extra_read", 32'(issued < l), 32'd1);
        chk("addrb", 32'(addrb), 32'((b + issued) % 4));
        issued++;
      end
      if (c == 1 && l > 0) chk("first_issue", 32'(enb), 32'd1);
      if (mode == 0 && l > 0 && (c == 2 || c == 3))
        chk("first_valid", 32'(m_valid), 32'(c == 3));
      if (pop) begin
        chk("data", m_data, mem[(b + popped) % 4]);
        popped++;
        if (popped == l) last_pop_c = c;
      end
      exp_done = (l == 0) ? (c == 1) : (last_pop_c >= 0 && c == last_pop_c + 1);
      exp_busy = (l == 0) ? 1'b0 : (last_pop_c < 0 || c <= last_pop_c);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      occ = occ + int'(inflight_prev) - int'(pop);
      inflight_prev = enb;
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      if (abort > 0 && popped == abort) finished = 1;
      if (l == 0 && c == 2) finished = 1;
      if (l > 0 && last_pop_c >= 0 && c == last_pop_c + 2) finished = 1;
    end
    chk("no_timeout", 32'(finished), 32'd1);
    if (abort == 0) begin
      chk("popped", 32'(popped), 32'(l));
      chk("issued", 32'(issued), 32'(l));
    end
  endtask

  initial begin
    mem[0] = 32'h01234567;
    mem[1] = 32'h89abcdef;
    mem[2] = 32'h10111213;
    mem[3] = 32'h14151617;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enb", 32'(enb), 32'd0);
    chk("rst_addrb", 32'(addrb), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_burst(0, 4, 0, 0, 0);
    run_burst(0, 4, 1, 0, 0);
    run_burst(3, 3, 0, 0, 0);
    run_burst(1, 0, 0, 0, 0);
    run_burst(1, 4, 0, 1, 0);
    run_burst(2, 4, 1, 1, 0);

    run_burst(0, 4, 0, 0, 2);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_enb", 32'(enb), 32'd0);
    chk("abort_addrb", 32'(addrb), 32'd0);
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_data", m_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(2, 2, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 4; k++) mem[k] = $urandom;
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
